// File: rtl/apb_slave_regfile.sv
// APB3 completer with a small bank of RW control registers, a read-only ID word,
// a completed-transfer counter, programmable wait states and slave-error decode.
module apb_slave_regfile #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          NUM_REGS    = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] paddr,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr,
    output logic [31:0] ctrl_out,
    output logic        proto_err
);

    typedef enum logic {IDLE, ACCESS} state_e;

    localparam logic [3:0]  WS        = 4'(WAIT_STATES);
    localparam logic [29:0] NUM_WORDS = 30'(NUM_REGS);
    localparam logic [29:0] ID_WORD   = 30'h10;
    localparam logic [29:0] CNT_WORD  = 30'h11;

    state_e      state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;
    logic [3:0]  idx_q, idx_d;
    logic        wr_q, wr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] xfer_cnt_q, xfer_cnt_d;
    logic        proto_err_q, proto_err_d;
    logic        commit;

    logic [31:0] regs_q [16];

    // Word offset from the base; byte alignment is checked on paddr directly.
    logic [29:0] woff;
    logic        is_rw, is_id, is_cnt, dec_err;
    logic [31:0] rd_mux;

    assign woff    = paddr[31:2] - BASE_ADDR[31:2];
    assign is_rw   = (woff < NUM_WORDS);
    assign is_id   = (woff == ID_WORD);
    assign is_cnt  = (woff == CNT_WORD);
    assign dec_err = (paddr[1:0] != 2'b00) || !(is_rw || is_id || is_cnt)
                     || (pwrite && (is_id || is_cnt));

    always_comb begin
        rd_mux = '0;
        if (is_id)
            rd_mux = ID_VALUE;
        else if (is_cnt)
            rd_mux = xfer_cnt_q;
        else if (is_rw)
            rd_mux = regs_q[woff[3:0]];
    end

    assign pready = (state_q == ACCESS) && (wcnt_q == WS);

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        idx_d       = idx_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        xfer_cnt_d  = xfer_cnt_q;
        proto_err_d = proto_err_q;
        commit      = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    idx_d   = woff[3:0];
                    wr_d    = pwrite;
                    wdata_d = pwdata;
                    err_d   = dec_err;
                    rdata_d = rd_mux;
                    wcnt_d  = 4'd0;
                    state_d = ACCESS;
                end else if (psel && penable) begin
                    proto_err_d = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    // Master walked away mid-transfer: drop it without side effects.
                    state_d     = IDLE;
                    proto_err_d = 1'b1;
                end else if (!pready) begin
                    wcnt_d = wcnt_q + 4'd1;
                end else if (penable) begin
                    state_d = IDLE;
                    if (!err_q) begin
                        xfer_cnt_d = xfer_cnt_q + 32'd1;
                        commit     = wr_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wcnt_q      <= 4'd0;
            idx_q       <= 4'd0;
            wr_q        <= 1'b0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            xfer_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            idx_q       <= idx_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            xfer_cnt_q  <= xfer_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Slots beyond NUM_REGS stay at reset value so the read mux can index all 16.
    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    regs_q[gi] <= '0;
                else if (gi < NUM_REGS && commit && idx_q == 4'(gi))
                    regs_q[gi] <= wdata_q;
            end
        end
    endgenerate

    assign prdata    = (pready && !wr_q && !err_q) ? rdata_q : 32'd0;
    assign pslverr   = pready && err_q;
    assign ctrl_out  = regs_q[0];
    assign proto_err = proto_err_q;

endmodule
